// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, character defaults and the command-word width
// helper shared by the UART command controller and its timeout counter.
package uart_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        COLLECT    = 3'd0,
        DISCARD    = 3'd1,
        PAD        = 3'd2,
        LATCH      = 3'd3,
        CLEAR      = 3'd4,
        WAIT_EMPTY = 3'd5
    } cmd_state_e;

    localparam logic [7:0] TERM_CHAR_DEF = 8'h0D;  // carriage return
    localparam logic [7:0] PAD_CHAR_DEF  = 8'h20;  // space

    // Width of one flattened command word
    function automatic int cmd_width(input int data_size, input int depth);
        return data_size * depth;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// cmd_timeout_counter: idle-cycle counter for a partially received command.
// Counts while run is high, restarts on clear, and raises expired for one
// cycle once LIMIT idle cycles have elapsed. Only compiled when the
// CMD_TIMEOUT_EN feature is enabled.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_counter #(
    parameter int LIMIT = 100_000_000,
    localparam int W    = $clog2(LIMIT + 1)
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] tcnt;

    // Idle counter: restarts on any received byte or when not armed
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (clear || !run) begin
            tcnt <= '0;
        end else if (tcnt != LAST) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout
    assign expired = run && !clear && (tcnt == LAST);

endmodule
`endif

// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: collects UART bytes into the 8-entry character FIFO
// until a terminator, pads the FIFO to full, latches the flattened FIFO as a
// command word, clears the FIFO and pulses cmd_valid.
// Optional feature: define CMD_TIMEOUT_EN to flush a partial command after
// TIMEOUT_CYCLES idle cycles (cmd_error pulse, no cmd_valid).
module uart_cmd_controller
    import uart_pkg::*;
#(
    parameter int                   DATA_SIZE      = 8,
    parameter int                   DEPTH          = 8,
    parameter logic [DATA_SIZE-1:0] TERM_CHAR      = DATA_SIZE'(TERM_CHAR_DEF),
    parameter logic [DATA_SIZE-1:0] PAD_CHAR       = DATA_SIZE'(PAD_CHAR_DEF),
    parameter int                   TIMEOUT_CYCLES = 100_000_000,
    localparam int                  CMD_W          = cmd_width(DATA_SIZE, DEPTH),
    localparam int                  CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [DATA_SIZE-1:0] rx_data,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    input  logic [CMD_W-1:0]     fifo_data,
    output logic                 fifo_write,
    output logic                 fifo_read,
    output logic [DATA_SIZE-1:0] fifo_wdata,
    output logic [CMD_W-1:0]     cmd_word,
    output logic [CNT_W-1:0]     cmd_len,
    output logic                 cmd_valid,
    output logic                 cmd_error,
    output logic                 busy
);

    localparam logic [2:0] ST_COLLECT    = COLLECT;
    localparam logic [2:0] ST_DISCARD    = DISCARD;
    localparam logic [2:0] ST_PAD        = PAD;
    localparam logic [2:0] ST_LATCH      = LATCH;
    localparam logic [2:0] ST_CLEAR      = CLEAR;
    localparam logic [2:0] ST_WAIT_EMPTY = WAIT_EMPTY;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;       // FIFO slots written, pads included
    logic [CNT_W-1:0] real_cnt;  // received characters only
    logic             discard;   // current command is being flushed
    logic             timeout_hit;

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .run       ((state == ST_COLLECT) && (cnt != '0)),
        .clear     (rx_done_tick),
        .expired   (timeout_hit)
    );
`else
    // No idle limit: a partial command waits for its terminator forever
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // Busy whenever the controller is not accepting new characters
    assign busy = (state != ST_COLLECT);

    // Command sequencer; FIFO strobes and result pulses are one-cycle registers
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state      <= ST_COLLECT;
            cnt        <= '0;
            real_cnt   <= '0;
            discard    <= 1'b0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            fifo_wdata <= '0;
            cmd_word   <= '0;
            cmd_len    <= '0;
            cmd_valid  <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_error  <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (rx_done_tick) begin
                        if (rx_data == TERM_CHAR) begin
                            // an empty command is ignored outright
                            if (cnt != '0) state <= ST_PAD;
                        end else if (cnt < FULL_CNT) begin
                            fifo_write <= 1'b1;
                            fifo_wdata <= rx_data;
                            cnt        <= cnt + 1'b1;
                            real_cnt   <= real_cnt + 1'b1;
                        end else begin
                            cmd_error <= 1'b1;
                            discard   <= 1'b1;
                            state     <= ST_DISCARD;
                        end
                    end else if (timeout_hit) begin
                        // flush the partial command through the discard path
                        cmd_error <= 1'b1;
                        discard   <= 1'b1;
                        state     <= ST_PAD;
                    end
                end
                ST_DISCARD: begin
                    if (rx_done_tick && (rx_data == TERM_CHAR)) state <= ST_PAD;
                end
                ST_PAD: begin
                    if (cnt < FULL_CNT) begin
                        fifo_write <= 1'b1;
                        fifo_wdata <= PAD_CHAR;
                        cnt        <= cnt + 1'b1;
                    end else if (fifo_full) begin
                        // full flag trails the last write by one cycle
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (!discard) begin
                        cmd_word  <= fifo_data;
                        cmd_len   <= real_cnt;
                        cmd_valid <= 1'b1;
                    end
                    state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    fifo_read <= 1'b1;
                    state     <= ST_WAIT_EMPTY;
                end
                ST_WAIT_EMPTY: begin
                    if (fifo_empty && !fifo_full) begin
                        cnt      <= '0;
                        real_cnt <= '0;
                        discard  <= 1'b0;
                        state    <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
